roberto_uc: RTL and testbench

Control unit for the roberto datapath: ultrasonic sensors, 7E1 TX/RX, reception registers and servos.
- TX FSM: each measurement period, triggers all three sensors, then transmits 12 ASCII chars over serial.
- RX FSM (independent): routes each received char into reception registers 1→2→3 cyclically.
- Both FSMs run on the same clock.

---
 rtl/roberto_pkg.sv | 39 +++
 rtl/roberto_uc_rx.sv | 81 ++++++++
 rtl/roberto_uc.sv | 140 ++++++++++++++
 tb/tb_roberto_uc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/roberto_pkg.sv
// roberto_pkg: shared definitions for the roberto control unit.
// Holds the TX/RX state encodings (which are also exported on the debug
// ports), the sensor/character geometry of a transmit cycle, the ASCII
// separator sent as the last character of every sensor, and the length of
// the measurement period used by the datapath period counter.
package roberto_pkg;

    // One transmit cycle: NUM_SENSORS sensors x CHARS_PER_SENSOR characters.
    localparam int unsigned CHARS_PER_SENSOR = 4;
    localparam int unsigned NUM_SENSORS      = 3;

    // Separator sent as the last character of each sensor group.
    localparam logic [6:0]  ASCII_HASH       = 7'h23;

    // Measurement period in clock cycles (terminal count of the period counter).
    localparam int unsigned MEAS_PERIOD      = 1_000_000;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARACAO  = 4'd1,
        MEDIR       = 4'd2,
        ESPERA      = 4'd3,
        TRANSMITE   = 4'd4,
        ESPERA_TX   = 4'd5,
        INC_CHAR    = 4'd6,
        PROX_SENSOR = 4'd7,
        FIM         = 4'd8
    } tx_state_t;

    typedef enum logic [2:0] {
        R_INICIAL = 3'd0,
        R_ESPERA  = 3'd1,
        R_CARREGA = 3'd2,
        R_CONTA   = 3'd3,
        R_CHECA   = 3'd4,
        R_LIBERA  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/roberto_uc_rx.sv
// roberto_uc_rx: reception FSM of the roberto control unit.
// Routes each received character into reception registers 1 -> 2 -> 3,
// cycling back to 1, and loads exactly once per pronto_recepcao assertion.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   pronto_recepcao     received character available (pulse or level)
//   Q_recepcao          reception register index counter (datapath)
//   zera_recpcao        clear of the index counter
//   zera_servos         clear of the servo registers
//   cont_recepcao       index counter enable
//   carrega_reg_1..3    reception register load enables (one-hot or none)
//   db_estado_rx        current state, for debug
module roberto_uc_rx
    import roberto_pkg::*;
#(
    parameter logic [1:0] ULT_REG = 2'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pronto_recepcao,
    input  logic [1:0] Q_recepcao,
    output logic       zera_recpcao,
    output logic       zera_servos,
    output logic       cont_recepcao,
    output logic       carrega_reg_1,
    output logic       carrega_reg_2,
    output logic       carrega_reg_3,
    output logic [2:0] db_estado_rx
);

    rx_state_t state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= R_INICIAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_INICIAL: state_d = R_ESPERA;
            R_ESPERA:  if (pronto_recepcao) state_d = R_CARREGA;
            R_CARREGA: state_d = R_CONTA;
            R_CONTA:   state_d = R_CHECA;
            R_CHECA:   state_d = R_LIBERA;
            // Hold here until the strobe drops so a level input loads once.
            R_LIBERA:  if (!pronto_recepcao) state_d = R_ESPERA;
            default:   state_d = R_INICIAL;
        endcase
    end

    always_comb begin
        zera_recpcao  = 1'b0;
        zera_servos   = 1'b0;
        cont_recepcao = 1'b0;
        carrega_reg_1 = 1'b0;
        carrega_reg_2 = 1'b0;
        carrega_reg_3 = 1'b0;
        case (state_q)
            R_INICIAL: begin
                zera_recpcao = 1'b1;
                zera_servos  = 1'b1;
            end
            R_CARREGA: begin
                case (Q_recepcao)
                    2'd0:    carrega_reg_1 = 1'b1;
                    2'd1:    carrega_reg_2 = 1'b1;
                    2'd2:    carrega_reg_3 = 1'b1;
                    default: ;
                endcase
            end
            R_CONTA: cont_recepcao = 1'b1;
            // Past the last register: one extra count wraps the 2-bit index to 0.
            R_CHECA: if (Q_recepcao > ULT_REG) cont_recepcao = 1'b1;
            default: ;
        endcase
    end

    assign db_estado_rx = state_q;

endmodule

// File: rtl/roberto_uc.sv
// roberto_uc: control unit of the roberto datapath.
// TX FSM: each measurement period triggers the sensors, then sends
// 4 characters per sensor for 3 sensors (12 frames) over the serial TX.
// The RX FSM lives in roberto_uc_rx and runs independently on the same clock.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   ligar                   level, enables the periodic measure/transmit loop
//   pronto_seg              period counter at terminal count
//   pronto_serial           TX frame finished
//   pronto_recepcao         RX character available
//   Q_2, Q_3, Q_recepcao    sensor, char and reception index counters
//   zera_*                  synchronous clears to the datapath
//   cont_*                  counter enables
//   medir, partida_tx       one-cycle sensor start / TX start pulses
//   carrega_reg_1..3        reception register load enables
//   pronto                  one-cycle pulse at the end of each transmit cycle
//   db_estado, db_estado_rx TX / RX state, for debug
module roberto_uc
    import roberto_pkg::*;
#(
    parameter logic [1:0] ULT_SENSOR = 2'(NUM_SENSORS - 1),
    parameter logic [1:0] ULT_CHAR   = 2'(CHARS_PER_SENSOR - 1),
    parameter logic [1:0] ULT_REG    = 2'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_seg,
    input  logic       pronto_serial,
    input  logic       pronto_recepcao,
    input  logic [1:0] Q_2,
    input  logic [1:0] Q_3,
    input  logic [1:0] Q_recepcao,
    output logic       zera_sensor,
    output logic       zera_serial,
    output logic       zera_seg,
    output logic       zera_2,
    output logic       zera_3,
    output logic       zera_servos,
    output logic       zera_recpcao,
    output logic       cont_seg,
    output logic       cont_2,
    output logic       cont_3,
    output logic       cont_recepcao,
    output logic       medir,
    output logic       partida_tx,
    output logic       carrega_reg_1,
    output logic       carrega_reg_2,
    output logic       carrega_reg_3,
    output logic       pronto,
    output logic [3:0] db_estado,
    output logic [2:0] db_estado_rx
);

    tx_state_t state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) state_q <= INICIAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:     if (ligar) state_d = PREPARACAO;
            PREPARACAO:  state_d = MEDIR;
            MEDIR:       state_d = ESPERA;
            ESPERA:      if (pronto_seg) state_d = TRANSMITE;
            TRANSMITE:   state_d = ESPERA_TX;
            ESPERA_TX: begin
                if (pronto_serial) state_d = (Q_3 == ULT_CHAR) ? PROX_SENSOR : INC_CHAR;
            end
            INC_CHAR:    state_d = TRANSMITE;
            PROX_SENSOR: state_d = (Q_2 == ULT_SENSOR) ? FIM : TRANSMITE;
            // ligar is only consulted here, so a drop mid-cycle lets the cycle finish.
            FIM:         state_d = ligar ? MEDIR : INICIAL;
            default:     state_d = INICIAL;
        endcase
    end

    always_comb begin
        zera_sensor = 1'b0;
        zera_serial = 1'b0;
        zera_seg    = 1'b0;
        zera_2      = 1'b0;
        zera_3      = 1'b0;
        cont_seg    = 1'b0;
        cont_2      = 1'b0;
        cont_3      = 1'b0;
        medir       = 1'b0;
        partida_tx  = 1'b0;
        pronto      = 1'b0;
        case (state_q)
            PREPARACAO: begin
                zera_sensor = 1'b1;
                zera_serial = 1'b1;
                zera_seg    = 1'b1;
                zera_2      = 1'b1;
                zera_3      = 1'b1;
            end
            MEDIR:     medir      = 1'b1;
            ESPERA:    cont_seg   = 1'b1;
            TRANSMITE: partida_tx = 1'b1;
            INC_CHAR:  cont_3     = 1'b1;
            PROX_SENSOR: begin
                // Advance to the next sensor and restart its character index.
                if (Q_2 != ULT_SENSOR) begin
                    cont_2 = 1'b1;
                    zera_3 = 1'b1;
                end
            end
            FIM: begin
                pronto   = 1'b1;
                zera_seg = 1'b1;
                zera_2   = 1'b1;
                zera_3   = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state_q;

    roberto_uc_rx #(
        .ULT_REG (ULT_REG)
    ) u_rx (
        .clock           (clock),
        .reset           (reset),
        .pronto_recepcao (pronto_recepcao),
        .Q_recepcao      (Q_recepcao),
        .zera_recpcao    (zera_recpcao),
        .zera_servos     (zera_servos),
        .cont_recepcao   (cont_recepcao),
        .carrega_reg_1   (carrega_reg_1),
        .carrega_reg_2   (carrega_reg_2),
        .carrega_reg_3   (carrega_reg_3),
        .db_estado_rx    (db_estado_rx)
    );

endmodule

// File: tb/tb_roberto_uc.sv
module tb_roberto_uc;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       pronto_seg;
    logic       pronto_serial = 1'b0;
    logic       pronto_recepcao;
    logic [1:0] Q_2 = '0;
    logic [1:0] Q_3 = '0;
    logic [1:0] Q_recepcao = '0;
    logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3;
    logic       zera_servos, zera_recpcao;
    logic       cont_seg, cont_2, cont_3, cont_recepcao;
    logic       medir, partida_tx, pronto;
    logic       carrega_reg_1, carrega_reg_2, carrega_reg_3;
    logic [3:0] db_estado;
    logic [2:0] db_estado_rx;

    roberto_uc dut (
        .clock           (clock),
        .reset           (reset),
        .ligar           (ligar),
        .pronto_seg      (pronto_seg),
        .pronto_serial   (pronto_serial),
        .pronto_recepcao (pronto_recepcao),
        .Q_2             (Q_2),
        .Q_3             (Q_3),
        .Q_recepcao      (Q_recepcao),
        .zera_sensor     (zera_sensor),
        .zera_serial     (zera_serial),
        .zera_seg        (zera_seg),
        .zera_2          (zera_2),
        .zera_3          (zera_3),
        .zera_servos     (zera_servos),
        .zera_recpcao    (zera_recpcao),
        .cont_seg        (cont_seg),
        .cont_2          (cont_2),
        .cont_3          (cont_3),
        .cont_recepcao   (cont_recepcao),
        .medir           (medir),
        .partida_tx      (partida_tx),
        .carrega_reg_1   (carrega_reg_1),
        .carrega_reg_2   (carrega_reg_2),
        .carrega_reg_3   (carrega_reg_3),
        .pronto          (pronto),
        .db_estado       (db_estado),
        .db_estado_rx    (db_estado_rx)
    );

    always #5 clock = ~clock;

    // All single-bit outputs, MSB first.
    logic [16:0] outs;
    assign outs = {zera_sensor, zera_serial, zera_seg, zera_2, zera_3,
                   zera_servos, zera_recpcao, cont_seg, cont_2, cont_3,
                   cont_recepcao, medir, partida_tx, carrega_reg_1,
                   carrega_reg_2, carrega_reg_3, pronto};
    localparam logic [16:0] OUTS_RESET = 17'h00C00; // zera_servos, zera_recpcao

    // ---------------- datapath model ----------------
    localparam logic [7:0] SEG_TC = 8'd15;
    logic [7:0] seg_cnt = '0;
    logic [3:0] tx_timer = '0;
    assign pronto_seg = (seg_cnt == SEG_TC);

    always @(posedge clock) begin
        if (zera_2) Q_2 <= '0; else if (cont_2) Q_2 <= Q_2 + 2'd1;
        if (zera_3) Q_3 <= '0; else if (cont_3) Q_3 <= Q_3 + 2'd1;
        if (zera_recpcao) Q_recepcao <= '0;
        else if (cont_recepcao) Q_recepcao <= Q_recepcao + 2'd1;
        if (zera_seg) seg_cnt <= '0; else if (cont_seg) seg_cnt <= seg_cnt + 8'd1;
        // Serial frame completes 10 cycles after its start pulse.
        pronto_serial <= 1'b0;
        if (reset) tx_timer <= '0;
        else if (partida_tx) tx_timer <= 4'd10;
        else if (tx_timer != 4'd0) begin
            tx_timer <= tx_timer - 4'd1;
            if (tx_timer == 4'd1) pronto_serial <= 1'b1;
        end
    end

    // ---------------- scoreboard / counters ----------------
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_partida = 0, n_pronto = 0, n_medir = 0, n_load = 0, n_crx = 0;
    logic [3:0] exp_tx_q[$];
    logic [2:0] exp_rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [3:0] et;
        logic [2:0] er;
        if (partida_tx) begin
            n_partida++;
            if (exp_tx_q.size() == 0) check("partida_unexpected", 32'({Q_2, Q_3}), 32'hFFFF);
            else begin
                et = exp_tx_q.pop_front();
                check("partida_seq", 32'({Q_2, Q_3}), 32'(et));
            end
        end
        if (carrega_reg_1 || carrega_reg_2 || carrega_reg_3) begin
            n_load++;
            if (exp_rx_q.size() == 0)
                check("load_unexpected", 32'({carrega_reg_1, carrega_reg_2, carrega_reg_3}), 32'h0);
            else begin
                er = exp_rx_q.pop_front();
                check("load_onehot", 32'({carrega_reg_1, carrega_reg_2, carrega_reg_3}), 32'(er));
            end
        end
        if (pronto) n_pronto++;
        if (medir) n_medir++;
        if (cont_recepcao) n_crx++;
    end

    // ---------------- RX vector table ----------------
    typedef struct {
        int unsigned len;       // cycles pronto_recepcao is held high
        logic [2:0]  exp_load;  // {reg_1, reg_2, reg_3}
        logic [1:0]  exp_q;     // Q_recepcao afterwards
        int unsigned exp_cont;  // cont_recepcao pulses
    } rx_vec_t;
    rx_vec_t vecs[5];

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    task automatic push_cycle;
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 4; c++)
                exp_tx_q.push_back({2'(s), 2'(c)});
    endtask

    initial begin
        int guard;
        vecs[0] = '{len: 1,  exp_load: 3'b100, exp_q: 2'd1, exp_cont: 1};
        vecs[1] = '{len: 1,  exp_load: 3'b010, exp_q: 2'd2, exp_cont: 1};
        vecs[2] = '{len: 1,  exp_load: 3'b001, exp_q: 2'd0, exp_cont: 2};
        vecs[3] = '{len: 1,  exp_load: 3'b100, exp_q: 2'd1, exp_cont: 1};
        vecs[4] = '{len: 50, exp_load: 3'b010, exp_q: 2'd2, exp_cont: 1};

        reset = 1'b1; ligar = 1'b0; pronto_recepcao = 1'b0;

        // ---- reset ----
        step();
        check("reset_outs", 32'(outs), 32'(OUTS_RESET));
        check("reset_estado", 32'(db_estado), 32'd0);
        check("reset_estado_rx", 32'(db_estado_rx), 32'd0);
        step();
        reset = 1'b0;
        check("post_reset_outs", 32'(outs), 32'(OUTS_RESET));
        step();
        check("idle_outs", 32'(outs), 32'd0);
        check("idle_estado", 32'(db_estado), 32'd0);
        check("idle_estado_rx", 32'(db_estado_rx), 32'd1);

        // ---- RX table ----
        foreach (vecs[i]) begin
            n_load = 0; n_crx = 0;
            exp_rx_q.push_back(vecs[i].exp_load);
            pronto_recepcao = 1'b1;
            repeat (vecs[i].len) step();
            pronto_recepcao = 1'b0;
            guard = 0;
            while (db_estado_rx != 3'd1 && guard < 50) begin step(); guard++; end
            check("rx_return_espera", 32'(db_estado_rx), 32'd1);
            check("rx_load_count", n_load, 1);
            check("rx_cont_count", n_crx, vecs[i].exp_cont);
            check("rx_q_after", 32'(Q_recepcao), 32'(vecs[i].exp_q));
        end
        check("rx_queue_empty", exp_rx_q.size(), 0);

        // ---- full TX cycle ----
        n_partida = 0; n_pronto = 0; n_medir = 0;
        push_cycle();
        ligar = 1'b1;
        guard = 0;
        while (n_pronto == 0 && guard < 3000) begin step(); guard++; end
        check("tx1_pronto", n_pronto, 1);
        check("tx1_partidas", n_partida, 12);
        check("tx1_medir_first", n_medir, 1);
        check("tx1_queue_empty", exp_tx_q.size(), 0);

        // ---- second cycle, ligar dropped after 5th frame ----
        n_partida = 0; n_pronto = 0; n_medir = 0;
        push_cycle();
        guard = 0;
        while (n_medir == 0 && guard < 20) begin step(); guard++; end
        check("tx2_medir_again", n_medir, 1);
        guard = 0;
        while (n_partida < 5 && guard < 2000) begin step(); guard++; end
        ligar = 1'b0;
        guard = 0;
        while (n_pronto == 0 && guard < 3000) begin step(); guard++; end
        check("tx2_pronto", n_pronto, 1);
        check("tx2_partidas", n_partida, 12);
        step();
        check("tx2_back_inicial", 32'(db_estado), 32'd0);
        n_medir = 0;
        repeat (100) step();
        check("tx2_no_medir", n_medir, 0);
        check("tx2_no_extra_partida", n_partida, 12);

        // ---- reset during ESPERA_TX ----
        push_cycle();
        n_pronto = 0;
        ligar = 1'b1;
        guard = 0;
        while (db_estado != 4'd5 && guard < 200) begin step(); guard++; end
        check("abort_reach_espera_tx", 32'(db_estado), 32'd5);
        reset = 1'b1;
        step();
        check("abort_estado", 32'(db_estado), 32'd0);
        check("abort_partida", 32'(partida_tx), 32'd0);
        exp_tx_q.delete();
        ligar = 1'b0;
        step();
        reset = 1'b0;
        n_partida = 0;
        repeat (60) step();
        check("abort_no_partida", n_partida, 0);
        check("abort_no_pronto", n_pronto, 0);
        check("abort_idle", 32'(db_estado), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
